// File: rtl/lane_deskew_fifo.sv
// Per-lane deskew FIFO: arms on window_cnt[2], starts writing at the first COM, show-ahead read, pops only when all lanes are non-empty.
// Optional DESKEW_SKP_DROP_EN: SKP symbols are never written once filling.
module lane_deskew_fifo #(
  parameter int         DEPTH = 8,
  parameter int         AW    = 3,
  parameter logic [7:0] COM   = 8'b10111100,
  parameter logic [7:0] SKP   = 8'b00011100
) (
  input  logic       clk_r_local,
  input  logic       rst_syn,
  input  logic [7:0] eb_data,
  input  logic       eb_valid,
  input  logic [2:0] window_cnt,
  input  logic       FIFO_all_not_empty,
  output logic       deskew_fifo_not_empty,
  output logic [7:0] lane_data,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, HUNT, FILL} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ne_q, ne_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];

  logic wr_req, full, push, pop;
  logic unused_window_lsbs;

  assign unused_window_lsbs = ^window_cnt[1:0];

  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    case (state_q)
      IDLE: if (window_cnt[2]) state_d = HUNT;
      HUNT: begin
        if (eb_valid && eb_data == COM) begin
          state_d = FILL;
          wr_req  = 1'b1;
        end
      end
      FILL: begin
`ifdef DESKEW_SKP_DROP_EN
        wr_req = eb_valid && (eb_data != SKP);
`else
        wr_req = eb_valid;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign full = (count_q == FULL_CNT);
  assign pop  = FIFO_all_not_empty && (count_q != '0);
  assign push = wr_req && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_req && full && !pop) ovf_d = 1'b1;
    ne_d = (count_d != '0);
  end

  always_ff @(posedge clk_r_local) begin
    if (rst_syn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ne_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ne_q     <= ne_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_r_local) begin
    if (push && !rst_syn) mem_q[wr_ptr_q] <= eb_data;
  end

  assign deskew_fifo_not_empty = ne_q;
  assign lane_data             = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow              = ovf_q;

endmodule
